// File: rtl/cpu_pkg.sv
// Shared CPU constants used by the fetch stage and its queue.
package cpu_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int unsigned PC_STEP          = 4;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO holding fetched {pc, instr} entries; the head is read combinationally.
module fetch_queue #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PW   = $clog2(DEPTH),
  localparam int unsigned CW   = PW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Pointers wrap for free because DEPTH is a power of two.
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; count_q alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= push_data;
  end

  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, captures {pc, instr} into fetch_queue, handles redirects.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int unsigned              ADDRESS_WIDTH = 32,
  parameter int unsigned              DATA_WIDTH    = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = ADDRESS_WIDTH'(RESET_PC_DEFAULT),
  parameter int unsigned              DEPTH         = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic [ADDRESS_WIDTH-1:0] instr_addr,
  input  logic [DATA_WIDTH-1:0]    instr,
  input  logic                     redirect_valid,
  input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
  input  logic                     id_ready,
  output logic                     if_valid,
  output logic [DATA_WIDTH-1:0]    if_instr,
  output logic [ADDRESS_WIDTH-1:0] if_pc,
  output logic                     misaligned
);

  localparam int unsigned EW = ADDRESS_WIDTH + DATA_WIDTH;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;
  logic                     misaligned_q, misaligned_d;
  logic                     push, pop;
  logic [EW-1:0]            head_data;
  logic [CW-1:0]            count;

  fetch_queue #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (push),
    .push_data ({pc_q, instr}),
    .pop       (pop),
    .head_data (head_data),
    .count     (count)
  );

  always_comb begin
    if_valid     = (count != '0);
    pop          = if_valid & id_ready & ~redirect_valid;
    // A full queue still accepts a word when the head leaves in the same cycle.
    push         = ~redirect_valid & ((count < CW'(DEPTH)) | pop);
    pc_d         = pc_q;
    misaligned_d = 1'b0;
    if (redirect_valid) begin
      pc_d         = {redirect_pc[ADDRESS_WIDTH-1:2], 2'b00};
      misaligned_d = |redirect_pc[1:0];
    end else if (push) begin
      pc_d = pc_q + ADDRESS_WIDTH'(PC_STEP);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q         <= RESET_PC;
      misaligned_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      misaligned_q <= misaligned_d;
    end
  end

  assign instr_addr = pc_q;
  assign misaligned = misaligned_q;
  assign if_instr   = if_valid ? head_data[DATA_WIDTH-1:0] : DATA_WIDTH'(NOP_INSTR);
  assign if_pc      = if_valid ? head_data[EW-1:DATA_WIDTH] : '0;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: memory word at byte address a is (a>>2)*0x11.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst, rst_hi;
  logic [31:0] instr_addr, instr, redirect_pc, if_instr, if_pc;
  logic        redirect_valid, id_ready, if_valid, misaligned;
  logic [31:0] instr_addr_hi, instr_hi, if_instr_hi, if_pc_hi;
  logic        if_valid_hi, misaligned_hi;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a >> 2) * 32'h11;
  endfunction

  always_comb instr    = mem_word(instr_addr);
  always_comb instr_hi = mem_word(instr_addr_hi);

  fetch_stage u_dut (
    .clk            (clk),
    .rst            (rst),
    .instr_addr     (instr_addr),
    .instr          (instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_ready       (id_ready),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .misaligned     (misaligned)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) u_dut_hi (
    .clk            (clk),
    .rst            (rst_hi),
    .instr_addr     (instr_addr_hi),
    .instr          (instr_hi),
    .redirect_valid (1'b0),
    .redirect_pc    (32'h0),
    .id_ready       (1'b1),
    .if_valid       (if_valid_hi),
    .if_instr       (if_instr_hi),
    .if_pc          (if_pc_hi),
    .misaligned     (misaligned_hi)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_head(input string tag, input logic [31:0] pc);
    check({tag, " valid"}, 32'(if_valid), 32'd1);
    check({tag, " pc"}, if_pc, pc);
    check({tag, " instr"}, if_instr, mem_word(pc));
  endtask

  initial begin
    rst = 1'b1; rst_hi = 1'b1;
    redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b0;
    tick(); tick();

    // 1: reset state, then streaming at one word per cycle
    check("rst valid", 32'(if_valid), 32'd0);
    check("rst instr", if_instr, 32'h0000_0013);
    check("rst pc", if_pc, 32'h0);
    check("rst misaligned", 32'(misaligned), 32'd0);
    check("rst addr", instr_addr, 32'h0);
    rst = 1'b0; id_ready = 1'b1;
    tick();
    check_head("stream0", 32'h0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      check_head("stream", 32'(4 * i));
    end

    // 2: stalled decode fills the queue and freezes the PC
    rst = 1'b1; id_ready = 1'b0;
    tick();
    rst = 1'b0;
    tick(); tick();
    check("fill addr2", instr_addr, 32'h8);
    tick(); tick(); tick();
    check("fill addr5", instr_addr, 32'h8);
    check_head("fill head", 32'h0);
    id_ready = 1'b1;
    tick(); check_head("drain1", 32'h4);
    check("drain addr", instr_addr, 32'hC);
    tick(); check_head("drain2", 32'h8);
    tick(); check_head("drain3", 32'hC);

    // 3: redirect while full
    id_ready = 1'b0;
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    tick();
    redirect_valid = 1'b0;
    check("redir flush", 32'(if_valid), 32'd0);
    check("redir addr", instr_addr, 32'h40);
    check("redir misaligned", 32'(misaligned), 32'd0);
    tick(); check_head("redir tgt", 32'h40);
    id_ready = 1'b1;
    tick(); check_head("redir next", 32'h44);

    // 4: misaligned redirect target
    redirect_valid = 1'b1; redirect_pc = 32'h42;
    tick();
    redirect_valid = 1'b0;
    check("mis pulse", 32'(misaligned), 32'd1);
    check("mis addr", instr_addr, 32'h40);
    check("mis flush", 32'(if_valid), 32'd0);
    tick();
    check("mis clear", 32'(misaligned), 32'd0);
    check_head("mis tgt", 32'h40);
    tick(); check_head("mis next", 32'h44);

    // back-to-back redirects: the later one wins
    redirect_valid = 1'b1; redirect_pc = 32'h80;
    tick();
    redirect_pc = 32'h100;
    tick();
    redirect_valid = 1'b0;
    check("b2b flush", 32'(if_valid), 32'd0);
    check("b2b addr", instr_addr, 32'h100);
    tick(); check_head("b2b tgt", 32'h100);
    tick(); check_head("b2b next", 32'h104);

    // 6: reset beats a concurrent misaligned redirect with a full queue
    id_ready = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h43;
    tick();
    check("mrst valid", 32'(if_valid), 32'd0);
    check("mrst instr", if_instr, 32'h0000_0013);
    check("mrst addr", instr_addr, 32'h0);
    check("mrst misaligned", 32'(misaligned), 32'd0);
    rst = 1'b0; redirect_valid = 1'b0; id_ready = 1'b1;
    tick(); check_head("mrst restart", 32'h0);

    // 5: PC wraps past the top of the address space
    rst_hi = 1'b0;
    tick();
    check("wrap pc0", if_pc_hi, 32'hFFFF_FFF8);
    check("wrap instr0", if_instr_hi, mem_word(32'hFFFF_FFF8));
    tick();
    check("wrap pc1", if_pc_hi, 32'hFFFF_FFFC);
    tick();
    check("wrap pc2", if_pc_hi, 32'h0000_0000);
    check("wrap valid", 32'(if_valid_hi), 32'd1);
    check("wrap misaligned", 32'(misaligned_hi), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
